// File: rtl/button_reader.sv
// button_reader: synchronises, debounces and classifies the BOOT and SW
// push-buttons, and keeps the colour index used by the LED driver.
// Optional feature macro: BUTTON_READER_AUTO_REPEAT_EN (auto-repeat of
// long pulses while a button stays held; SW long pulses step the colour
// index down).
// Button index 0 is BOOT, index 1 is SW.
module button_reader #(
    parameter int DEBOUNCE_CYCLES   = 120000,
    parameter int LONG_PRESS_CYCLES = 12000000,
    parameter int NUM_COLORS        = 6,
    parameter int REPEAT_CYCLES     = 3000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       BOOT,
    input  logic       SW,
    output logic       boot_level,
    output logic       sw_level,
    output logic       boot_short,
    output logic       boot_long,
    output logic       sw_short,
    output logic       sw_long,
    output logic [2:0] color_idx
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
`ifdef BUTTON_READER_AUTO_REPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES + 1);
`endif

    typedef enum logic [1:0] {IDLE, HELD, LONG} state_t;

    logic [1:0]    sync1_q, sync2_q;
    logic [1:0]    pressed;
    logic [1:0]    level_q;
    logic [DW-1:0] deb_cnt_q [2];
    logic [1:0]    accept, rise, fall;
    state_t        state_q [2];
    logic [HW-1:0] hold_cnt_q [2];
`ifdef BUTTON_READER_AUTO_REPEAT_EN
    logic [RW-1:0] rep_cnt_q [2];
`endif
    logic [1:0]    short_q, long_q;
    logic [2:0]    color_q, color_d;
    logic          inc, dec;

    assign pressed = ~sync2_q;

    // Two-flop synchronisers; pins idle high (released).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 2'b11;
            sync2_q <= 2'b11;
        end else begin
            sync1_q <= {SW, BOOT};
            sync2_q <= sync1_q;
        end
    end

    // Level change is accepted on the last of DEBOUNCE_CYCLES differing samples.
    always_comb begin
        accept = '0;
        rise   = '0;
        fall   = '0;
        for (int b = 0; b < 2; b++) begin
            accept[b] = (pressed[b] != level_q[b]) &&
                        (deb_cnt_q[b] == DW'(DEBOUNCE_CYCLES - 1));
            rise[b]   = accept[b] & pressed[b];
            fall[b]   = accept[b] & ~pressed[b];
        end
    end

    // Debounce counters and debounced levels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= '0;
            for (int b = 0; b < 2; b++) deb_cnt_q[b] <= '0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (pressed[b] == level_q[b]) begin
                    deb_cnt_q[b] <= '0;
                end else if (accept[b]) begin
                    level_q[b]   <= pressed[b];
                    deb_cnt_q[b] <= '0;
                end else begin
                    deb_cnt_q[b] <= deb_cnt_q[b] + DW'(1);
                end
            end
        end
    end

    // Press classifier: enters HELD on the same edge the level rises, so a
    // long pulse appears exactly LONG_PRESS_CYCLES after the level edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            short_q <= '0;
            long_q  <= '0;
            for (int b = 0; b < 2; b++) begin
                state_q[b]    <= IDLE;
                hold_cnt_q[b] <= '0;
`ifdef BUTTON_READER_AUTO_REPEAT_EN
                rep_cnt_q[b]  <= '0;
`endif
            end
        end else begin
            short_q <= '0;
            long_q  <= '0;
            for (int b = 0; b < 2; b++) begin
                case (state_q[b])
                    IDLE: begin
                        if (rise[b]) begin
                            state_q[b]    <= HELD;
                            hold_cnt_q[b] <= '0;
                        end
                    end
                    HELD: begin
                        if (fall[b]) begin
                            short_q[b] <= 1'b1;
                            state_q[b] <= IDLE;
                        end else if (hold_cnt_q[b] == HW'(LONG_PRESS_CYCLES - 1)) begin
                            long_q[b]  <= 1'b1;
                            state_q[b] <= LONG;
`ifdef BUTTON_READER_AUTO_REPEAT_EN
                            rep_cnt_q[b] <= '0;
`endif
                        end else begin
                            hold_cnt_q[b] <= hold_cnt_q[b] + HW'(1);
                        end
                    end
                    LONG: begin
                        if (fall[b]) begin
                            state_q[b] <= IDLE;
`ifdef BUTTON_READER_AUTO_REPEAT_EN
                            rep_cnt_q[b] <= '0;
                        end else if (rep_cnt_q[b] == RW'(REPEAT_CYCLES - 1)) begin
                            long_q[b]    <= 1'b1;
                            rep_cnt_q[b] <= '0;
                        end else begin
                            rep_cnt_q[b] <= rep_cnt_q[b] + RW'(1);
`endif
                        end
                    end
                    default: state_q[b] <= IDLE;
                endcase
            end
        end
    end

    // Next colour index from the registered pulses; BOOT long forces zero.
    always_comb begin
        color_d = color_q;
        inc     = short_q[0];
`ifdef BUTTON_READER_AUTO_REPEAT_EN
        dec     = short_q[1] | long_q[1];
`else
        dec     = short_q[1];
`endif
        if (long_q[0]) begin
            color_d = '0;
        end else if (inc && !dec) begin
            color_d = (color_q == 3'(NUM_COLORS - 1)) ? 3'd0 : color_q + 3'd1;
        end else if (dec && !inc) begin
            color_d = (color_q == 3'd0) ? 3'(NUM_COLORS - 1) : color_q - 3'd1;
        end
    end

    // Colour index register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) color_q <= '0;
        else        color_q <= color_d;
    end

    assign boot_level = level_q[0];
    assign sw_level   = level_q[1];
    assign boot_short = short_q[0];
    assign sw_short   = short_q[1];
    assign boot_long  = long_q[0];
    assign sw_long    = long_q[1];
    assign color_idx  = color_q;

endmodule

// File: doc/button_reader.md
Name: button_reader

Overview:
- Input-side counterpart to the RGB colour-cycler LED driver; conditions the BOOT and SW push-buttons.
- Per button: synchronises and debounces the pin, then classifies each press as short or long.
- Maintains a colour index that the LED driver consumes in place of its free-running counter.
- All outputs are registered; one clock domain.

Parameters:
DEBOUNCE_CYCLES, 120000, consecutive stable samples required to accept a level change (10 ms at 12 MHz)
LONG_PRESS_CYCLES, 12000000, hold duration that classifies a press as long (1 s at 12 MHz)
NUM_COLORS, 6, colour index range 0..NUM_COLORS-1
REPEAT_CYCLES, 3000000, auto-repeat period (used only with the optional feature)

Ports:
clk  input  1  12 MHz system clock
rst_n  input  1  reset; asynchronous, active-low
BOOT  input  1  raw BOOT button pin; active-low (0 = pressed)
SW  input  1  raw SW button pin; active-low (0 = pressed)
boot_level  output  1  debounced BOOT state, 1 = pressed
sw_level  output  1  debounced SW state, 1 = pressed
boot_short  output  1  one-cycle pulse on release of a short BOOT press
boot_long  output  1  one-cycle pulse when a BOOT hold reaches LONG_PRESS_CYCLES
sw_short  output  1  one-cycle pulse on release of a short SW press
sw_long  output  1  one-cycle pulse when an SW hold reaches LONG_PRESS_CYCLES
color_idx  output  3  current colour index, 0..NUM_COLORS-1

Behaviour:
Reset (rst_n low):
- All outputs go to 0 immediately.
- Synchroniser flops reset to released (1).
- Counters reset to 0; FSMs reset to IDLE.
- Reset asserted mid-press: the press is discarded. After release of reset, a still-held button is seen as a new press once debounced.

Synchroniser:
- Two flops per pin.
- Internal pressed = ~sync2.

Debounce (per button):
- pressed == level: cnt <= 0.
- pressed != level: cnt increments.
- cnt == DEBOUNCE_CYCLES-1 with a still-differing sample: level <= pressed, cnt <= 0.
- Any matching sample before that point clears cnt.
- Latency from a clean pin edge to level change: 2 + DEBOUNCE_CYCLES cycles.

Press FSM (per button), states IDLE, HELD, LONG:
- IDLE: level rising -> HELD, hold_cnt <= 0.
- HELD: hold_cnt increments each cycle.
  - Level falling -> short pulse next cycle; go to IDLE.
  - hold_cnt == LONG_PRESS_CYCLES-1 -> long pulse next cycle; go to LONG.
  - Falling and threshold in the same cycle: falling wins (short pulse only).
- LONG: level falling -> IDLE; no pulse.
- Pulses are exactly one cycle. At most one of short/long is issued per press.

Colour index (updated the cycle after pulses are registered):
- boot_short: +1; wraps from NUM_COLORS-1 to 0.
- sw_short: -1; wraps from 0 to NUM_COLORS-1.
- boot_short and sw_short in the same cycle: no change.
- boot_long: color_idx <= 0. This has priority over any same-cycle short pulse.
- sw_long: no effect on color_idx.

Optional Feature:
Macro: BUTTON_READER_AUTO_REPEAT_EN
- Defined:
  - In LONG, a repeat counter runs and emits a further long pulse every REPEAT_CYCLES while the button stays pressed.
  - Counter restarts on LONG entry and clears on release.
  - Each SW long pulse also decrements color_idx, with the same wrap as sw_short.
- Undefined:
  - Exactly one long pulse per hold.
  - sw_long does not affect color_idx.
  - No repeat logic is synthesised.

Test Plan:
Simulate with DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20, REPEAT_CYCLES=8.
- Reset then idle: pins held at 1 for 50 cycles -> all outputs 0; color_idx = 0.
- Bounce: BOOT toggles 0/1 every 2 cycles for 20 cycles, then returns to 1 -> boot_level never rises; no pulses.
- Short press: BOOT=0 for 10 cycles, then 1 -> boot_level high 6 cycles after the pin edge; one boot_short pulse after release; color_idx 0 -> 1. Repeat 5 more times -> color_idx wraps to 0.
- SW short from reset -> color_idx = 5. SW and BOOT short pulses in the same cycle -> color_idx unchanged.
- Long press: BOOT=0 for 40 cycles -> one boot_long pulse 20 cycles after boot_level rises; color_idx = 0; no boot_short on release. With BUTTON_READER_AUTO_REPEAT_EN defined, SW held 40 cycles -> sw_long pulses at 20, 28, 36 cycles after sw_level rises; color_idx decrements 3 times.
- Reset mid-hold: rst_n low at cycle 10 of a BOOT hold -> outputs 0 at once; no pulse issued; re-press is detected normally after reset is released.
